regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register_file write port between two writeback requesters:
//  port 0 is the ALU result and port 1 is load/multi-cycle results.
//  Each port has a one-entry holding buffer and a valid/ready handshake.
//  A round-robin arbiter drains one buffer per cycle into write_reg/write_data/write_enable.
//  pending_mask lets decode stall on registers that still have a buffered write.
// PARAMETERS
//  ADDR_W  5   register address width; NUM_REGS = 2**ADDR_W
//  DATA_W  32  register data width
//  CNT_W   8   width of the saturating contention counter
// PORTS
//  clk            in   1         rising-edge clock
//  areset         in   1         asynchronous reset, active-high
//  in0_valid      in   1         port 0 write request
//  in0_ready      out  1         port 0 can accept this cycle
//  in0_addr       in   ADDR_W    port 0 destination register
//  in0_data       in   DATA_W    port 0 write data
//  in1_valid      in   1         port 1 write request
//  in1_ready      out  1         port 1 can accept this cycle
//  in1_addr       in   ADDR_W    port 1 destination register
//  in1_data       in   DATA_W    port 1 write data
//  write_reg      out  ADDR_W    to register_file write_reg
//  write_data     out  DATA_W    to register_file write_data
//  write_enable   out  1         to register_file write_enable
//  pending_mask   out  NUM_REGS  bit r=1: buffered write to register r outstanding
//  contention_cnt out  CNT_W     cycles in which both buffers were valid, saturating
// BEHAVIOUR
//  - State: bv[1:0] buffer-valid flags, baddr/bdata per port, rr_last (last granted port), contention_cnt.
//  - Reset (areset=1, async): bv=0, rr_last=1 so port 0 wins the first tie, contention_cnt=0.
//    Outputs immediately: write_enable=0, write_reg=0, write_data=0, pending_mask=0, inX_ready=1.
//    Reset mid-operation discards buffered writes; none reach the write port.
//  - inX_ready = !bv[X] | grant[X], all combinational.
//    A handshake (valid & ready) loads the buffer at the clock edge.
//  - Grant, combinational from bv:
//    - only one bv set -> that port;
//    - both set -> the port != rr_last;
//    - none set -> no grant.
//    On a grant, rr_last <= granted port.
//  - Write port, combinational from the granted buffer:
//    - write_enable = grant & (baddr != 0);
//    - write_reg/write_data = the granted buffer's fields, or 0 when there is no grant.
//  - Register 0: writes are accepted and drained, but write_enable stays 0 and pending_mask[0] is always 0.
//  - Latency: a request accepted at edge N is written at edge N+1 if uncontended, otherwise at N+2.
//    Throughput is 1 write/cycle in total.
//  - Drain and refill: a granted buffer may reload in the same cycle, so one port can sustain back-to-back writes.
//  - Same-address writes from both ports complete in grant order; the later grant wins.
//  - pending_mask[r] = OR over X of bv[X] & (baddr[X]==r), for r != 0.
//  - contention_cnt += 1 on each edge where bv==2'b11; it holds at 2**CNT_W-1.
// CONFIGURATION
//  REGFILE_WB_BYPASS_EN
//  - Defined: when bv==0, incoming valid requests are arbitrated directly with the same rr rule.
//    - The winner drives the write port in that cycle (0-edge latency) and is not buffered.
//    - The loser is buffered.
//    - pending_mask ignores the bypassed request.
//  - Undefined: every request passes through its buffer (minimum latency 1 edge).
// TESTING
//  1. Buffers full, assert areset between edges -> write_enable=0, pending_mask=0, both ready=1 immediately;
//     after release no write occurs.
//  2. in0 addr=5 data=0xDEADBEEF at edge N -> pending_mask=0x20 during N..N+1; write_enable=1, write_reg=5 at edge N+1.
//  3. After reset, in0 (3,0x11) and in1 (4,0x22) at same edge -> reg3 written then reg4;
//     contention_cnt=1; next tie grants port 1 first.
//  4. in1 addr=0 data=0xFFFFFFFF -> handshake completes, write_enable stays 0, pending_mask stays 0.
//  5. in0 valid every cycle for 10 cycles, in1 idle -> in0_ready stays 1, 10 consecutive writes in order;
//     then hold both buffers full 300 cycles -> contention_cnt=255.
//  6. With REGFILE_WB_BYPASS_EN, idle unit, in0 (7,0xA5) -> write_enable=1, write_reg=7 in the same cycle;
//     without it -> one cycle later.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter for the register file write port: one-entry buffer per port,
// round-robin drain, pending mask for decode. Optional same-cycle bypass: REGFILE_WB_BYPASS_EN.

module regfile_wb_slot #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              drain,
    input  logic              bypass,
    output logic              buf_valid,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_data
);
    logic load;

    // drain is only raised while the buffer holds data, so a granted slot can refill
    assign in_ready = !buf_valid | drain;
    assign load     = in_valid & in_ready & !bypass;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_addr  <= in_addr;
            buf_data  <= in_data;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   in0_valid,
    output logic                   in0_ready,
    input  logic [ADDR_W-1:0]      in0_addr,
    input  logic [DATA_W-1:0]      in0_data,
    input  logic                   in1_valid,
    output logic                   in1_ready,
    input  logic [ADDR_W-1:0]      in1_addr,
    input  logic [DATA_W-1:0]      in1_data,
    output logic [ADDR_W-1:0]      write_reg,
    output logic [DATA_W-1:0]      write_data,
    output logic                   write_enable,
    output logic [2**ADDR_W-1:0]   pending_mask,
    output logic [CNT_W-1:0]       contention_cnt
);
    localparam int NUM_PORTS = 2;
    localparam int NUM_REGS  = 2**ADDR_W;

    logic [NUM_PORTS-1:0]             in_valid, in_ready, bv;
    logic [NUM_PORTS-1:0]             buf_grant, byp_grant, grant;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] in_addr, baddr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] in_data, bdata;
    logic                             rr_last;
    logic                             sel;
    logic [ADDR_W-1:0]                wr_addr;
    logic [DATA_W-1:0]                wr_data;

    assign in_valid  = {in1_valid, in0_valid};
    assign in_addr   = {in1_addr, in0_addr};
    assign in_data   = {in1_data, in0_data};
    assign in0_ready = in_ready[0];
    assign in1_ready = in_ready[1];

    // One-hot round-robin pick; on a tie the port that did not win last time goes.
    function automatic logic [NUM_PORTS-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                     input logic last);
        case (req)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return last ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
            regfile_wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
                .clk       (clk),
                .areset    (areset),
                .in_valid  (in_valid[p]),
                .in_ready  (in_ready[p]),
                .in_addr   (in_addr[p]),
                .in_data   (in_data[p]),
                .drain     (buf_grant[p]),
                .bypass    (byp_grant[p]),
                .buf_valid (bv[p]),
                .buf_addr  (baddr[p]),
                .buf_data  (bdata[p])
            );
        end
    endgenerate

    assign buf_grant = rr_pick(bv, rr_last);

`ifdef REGFILE_WB_BYPASS_EN
    // Idle unit: the incoming winner goes straight to the write port, the loser buffers.
    // Gated by reset so the write port stays quiet while areset is high.
    assign byp_grant = (bv == '0 && !areset) ? rr_pick(in_valid, rr_last) : '0;
`else
    assign byp_grant = '0;
`endif

    assign grant = buf_grant | byp_grant;
    assign sel   = grant[1];

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        if (buf_grant != '0) begin
            wr_addr = baddr[sel];
            wr_data = bdata[sel];
        end else if (byp_grant != '0) begin
            wr_addr = in_addr[sel];
            wr_data = in_data[sel];
        end
    end

    // Register 0 is hardwired: drain the write but never strobe the file.
    assign write_enable = (grant != '0) && (wr_addr != '0);
    assign write_reg    = wr_addr;
    assign write_data   = wr_data;

    always_comb begin
        pending_mask = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (bv[p]) pending_mask[baddr[p]] = 1'b1;
        pending_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rr_last        <= 1'b1;
            contention_cnt <= '0;
        end else begin
            if (grant != '0) rr_last <= sel;
            if (bv == 2'b11 && contention_cnt != {CNT_W{1'b1}})
                contention_cnt <= contention_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued at stimulus time
// and popped by a write-port monitor; directed checks cover reset, latency, r0 and saturation.

module tb_regfile_wb_arbiter;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        areset;
    logic        in0_valid, in0_ready, in1_valid, in1_ready;
    logic [4:0]  in0_addr, in1_addr, write_reg;
    logic [31:0] in0_data, in1_data, write_data;
    logic        write_enable;
    logic [31:0] pending_mask;
    logic [7:0]  contention_cnt;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    bit   sb_en = 1'b1;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .areset(areset),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_addr(in0_addr), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_addr(in1_addr), .in1_data(in1_data),
        .write_reg(write_reg), .write_data(write_data), .write_enable(write_enable),
        .pending_mask(pending_mask), .contention_cnt(contention_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.r = r;
        e.d = d;
        q.push_back(e);
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0; in0_addr = '0; in0_data = '0;
        in1_valid = 1'b0; in1_addr = '0; in1_data = '0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        cyc();
        areset = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
        chk(tag, q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (sb_en && write_enable) begin
            if (q.size() == 0) begin
                chk("unexpected_write", write_reg, 6'h3f);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_reg", write_reg, e.r);
                chk("wr_data", write_data, e.d);
            end
        end
    end

    initial begin
        idle_inputs();
        areset = 1'b1;
        #1;
        chk("rst_we", write_enable, 0);
        chk("rst_wreg", write_reg, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_pend", pending_mask, 0);
        chk("rst_rdy0", in0_ready, 1);
        chk("rst_rdy1", in1_ready, 1);
        chk("rst_cnt", contention_cnt, 0);
        cyc();
        cyc();
        areset = 1'b0;

        // single uncontended write: pending until written one edge later
        in0_valid = 1'b1; in0_addr = 5; in0_data = 32'hDEADBEEF;
        push(5, 32'hDEADBEEF);
        #1;
        chk("t2_rdy", in0_ready, 1);
        chk("t2_we_same", write_enable, BYP);
        cyc();
        idle_inputs();
        #1;
        chk("t2_pend", pending_mask, BYP ? 32'h0 : 32'h20);
        chk("t2_we_next", write_enable, !BYP);
        cyc();
        #1;
        chk("t2_pend_clr", pending_mask, 0);
        chk("t2_we_done", write_enable, 0);
        drain("t2_drain");

        // fill both buffers, then reset between edges: nothing may come out
        sb_en = 1'b0;
        in0_valid = 1'b1; in0_addr = 1; in0_data = 32'h101;
        in1_valid = 1'b1; in1_addr = 2; in1_data = 32'h202;
        cyc();
        cyc();
        idle_inputs();
        #1;
        chk("t1_full_pend", pending_mask, 32'h6);
        #1;
        areset = 1'b1;
        #1;
        chk("t1_we", write_enable, 0);
        chk("t1_pend", pending_mask, 0);
        chk("t1_rdy0", in0_ready, 1);
        chk("t1_rdy1", in1_ready, 1);
        cyc();
        areset = 1'b0;
        sb_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t1_quiet", write_enable, 0);
            cyc();
        end

        // simultaneous requests, then a refill on port 0 so the next tie goes to port 1
        in0_valid = 1'b1; in0_addr = 3; in0_data = 32'h11;
        in1_valid = 1'b1; in1_addr = 4; in1_data = 32'h22;
        push(3, 32'h11); push(4, 32'h22); push(8, 32'h33);
        cyc();
        in1_valid = 1'b0;
        in0_addr = 8; in0_data = 32'h33;
        #1;
        chk("t3_rdy0", in0_ready, 1);
        chk("t3_first", write_reg, BYP ? 4 : 3);
        cyc();
        idle_inputs();
        #1;
        chk("t3_cnt1", contention_cnt, BYP ? 0 : 1);
        chk("t3_tie", write_reg, BYP ? 8 : 4);
        cyc();
        #1;
        chk("t3_cnt2", contention_cnt, BYP ? 0 : 2);
        drain("t3_drain");

        // register 0: accepted, drained, never written or pending
        in1_valid = 1'b1; in1_addr = 0; in1_data = 32'hFFFFFFFF;
        #1;
        chk("t4_rdy1", in1_ready, 1);
        chk("t4_we_same", write_enable, 0);
        cyc();
        idle_inputs();
        #1;
        chk("t4_we", write_enable, 0);
        chk("t4_pend", pending_mask, 0);
        chk("t4_rdy_back", in1_ready, 1);
        cyc();
        #1;
        chk("t4_we2", write_enable, 0);

        // back-to-back stream on port 0
        for (int i = 0; i < 10; i++) begin
            in0_valid = 1'b1; in0_addr = 5'(10 + i); in0_data = 32'h500 + i;
            push(5'(10 + i), 32'h500 + i);
            #1;
            chk("t5_rdy0", in0_ready, 1);
            cyc();
        end
        idle_inputs();
        drain("t5_drain");

        // both buffers held full long enough to saturate the counter
        do_reset();
        sb_en = 1'b0;
        for (int i = 0; i < 302; i++) begin
            in0_valid = 1'b1; in0_addr = 5'($urandom_range(1, 31)); in0_data = $urandom;
            in1_valid = 1'b1; in1_addr = 5'($urandom_range(1, 31)); in1_data = $urandom;
            cyc();
        end
        idle_inputs();
        #1;
        chk("t5_sat", contention_cnt, 255);
        cyc();
        #1;
        chk("t5_sat_hold", contention_cnt, 255);
        do_reset();
        sb_en = 1'b1;
        #1;
        chk("t5_cnt_rst", contention_cnt, 0);

        // latency from an idle unit
        in0_valid = 1'b1; in0_addr = 7; in0_data = 32'hA5;
        push(7, 32'hA5);
        #1;
        chk("t6_we_same", write_enable, BYP);
        chk("t6_reg_same", write_reg, BYP ? 7 : 0);
        cyc();
        idle_inputs();
        #1;
        chk("t6_we_next", write_enable, !BYP);
        chk("t6_reg_next", write_reg, BYP ? 0 : 7);
        drain("t6_drain");

        cyc();
        chk("final_queue", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
